// File: rtl/mem_burst_responder.sv
// Line-burst memory responder; optional critical-word-first wrap under MEM_BURST_WRAP_EN.
// First beat LATENCY cycles after acceptance, BURST_LEN beats back to back; req_ready only in IDLE, beats never stall.
module mem_burst_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int BURST_LEN  = 4,
  parameter int LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  wdata,
  output logic                         beat_valid,
  output logic [$clog2(BURST_LEN)-1:0] beat_idx,
  output logic                         beat_last,
  output logic [31:0]                  rdata
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [IDX_W-1:0]            beat_cnt, beat_cnt_nxt;
  logic                        wr_q;
  logic [ADDR_WIDTH-IDX_W-1:0] base_q;
  logic [IDX_W-1:0]            start_q;
  logic [IDX_W-1:0]            req_start;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic                        accept;
  logic                        unused_addr;

  logic [31:0] mem [2**ADDR_WIDTH];

`ifdef MEM_BURST_WRAP_EN
  assign req_start = req_addr[IDX_W+1:2];
`else
  assign req_start = '0;
`endif

  // Byte-offset and high address bits alias silently.
  assign unused_addr = ^req_addr;
  assign accept      = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      beat_cnt <= '0;
      wr_q     <= 1'b0;
      base_q   <= '0;
      start_q  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (accept) begin
        wr_q    <= req_write;
        base_q  <= req_addr[ADDR_WIDTH+1:IDX_W+2];
        start_q <= req_start;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    beat_cnt_nxt = beat_cnt;
    req_ready    = 1'b0;
    beat_valid   = 1'b0;
    beat_last    = 1'b0;
    case (state)
      IDLE: begin
        req_ready    = 1'b1;
        beat_cnt_nxt = '0;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt = BURST;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = BURST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      BURST: begin
        beat_valid   = 1'b1;
        beat_last    = (beat_cnt == LAST_CNT);
        beat_cnt_nxt = beat_cnt + IDX_W'(1);
        if (beat_last) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index wraps naturally at IDX_W bits, giving modulo-BURST_LEN order.
  assign beat_idx = beat_valid ? (start_q + beat_cnt) : '0;
  assign mem_addr = {base_q, beat_idx};
  assign rdata    = (beat_valid && !wr_q) ? mem[mem_addr] : '0;

  // Storage has no reset; a burst cut short by reset leaves earlier beats in place.
  always_ff @(posedge clk) begin
    if (beat_valid && wr_q) begin
      mem[mem_addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder with a beat scoreboard and a word-level memory model.
module tb_mem_burst_responder;
  localparam int AW  = 12;
  localparam int BL  = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] wdata;
  logic        req_ready, beat_valid, beat_last;
  logic [1:0]  beat_idx;
  logic [31:0] rdata;

  logic [31:0] wbuf [4];

  mem_burst_responder #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wdata(wdata),
    .beat_valid(beat_valid), .beat_idx(beat_idx), .beat_last(beat_last), .rdata(rdata)
  );

  // The initiator supplies the write word matching the index the responder asks for.
  assign wdata = wbuf[beat_idx];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [1:0]  idx;
    bit          last;
    logic [31:0] dat;
    int          waddr;
  } beat_t;

  beat_t       q[$];
  logic [31:0] mdl [int];
  int          tests = 0;
  int          fails = 0;
  int          busy_from = -1;
  int          busy_to = -2;
  bit          pend_vld = 0;
  int          pend_a;
  logic [31:0] pend_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t       e;
    bit          exp_rdy;
    logic [31:0] exp_rd;
    if (reset_n) begin
      exp_rdy = !(cyc >= busy_from && cyc <= busy_to);
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("beat_valid", {31'd0, beat_valid}, 32'd1);
        chk("beat_idx", {30'd0, beat_idx}, {30'd0, e.idx});
        chk("beat_last", {31'd0, beat_last}, {31'd0, e.last});
        if (e.wr) begin
          pend_vld = 1;
          pend_a   = e.waddr;
          pend_d   = e.dat;
        end else begin
          exp_rd = mdl.exists(e.waddr) ? mdl[e.waddr] : 32'hDEAD_BEEF;
          chk("rdata", rdata, exp_rd);
        end
      end else begin
        chk("idle_valid", {31'd0, beat_valid}, 32'd0);
        chk("idle_idx", {30'd0, beat_idx}, 32'd0);
        chk("idle_last", {31'd0, beat_last}, 32'd0);
        chk("idle_rdata", rdata, 32'd0);
      end
    end
  end

  // A write beat lands in storage only if reset is still high at the edge ending it.
  always @(posedge clk) begin
    if (pend_vld && reset_n) mdl[pend_a] = pend_d;
    pend_vld = 0;
  end

  // Called just after a falling edge; returns the cycle number of acceptance.
  task automatic request(input bit w, input logic [31:0] addr, output int acc);
    bit    got;
    int    word, base, start;
    beat_t e;
    got = 0;
    acc = -1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    for (int k = 0; k < 40 && !got; k++) begin
      if (req_ready) begin
        got   = 1;
        acc   = cyc + 1;
        word  = int'(addr >> 2) & ((1 << AW) - 1);
        base  = word & ~(BL - 1);
`ifdef MEM_BURST_WRAP_EN
        start = word & (BL - 1);
`else
        start = 0;
`endif
        for (int i = 0; i < BL; i++) begin
          e.cyc   = acc + LAT + i;
          e.wr    = w;
          e.idx   = 2'((start + i) % BL);
          e.last  = (i == BL - 1);
          e.dat   = wbuf[e.idx];
          e.waddr = base + int'(e.idx);
          q.push_back(e);
        end
        busy_from = acc;
        busy_to   = acc + LAT + BL - 1;
      end
      @(negedge clk); #1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) begin
      @(negedge clk); #1;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic set_wbuf(input logic [31:0] b);
    for (int i = 0; i < 4; i++) wbuf[i] = b + 32'(i);
  endtask

  initial begin
    int a, a1, a2;
    set_wbuf(32'h0);
    #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, beat_valid}, 32'd0);
    chk("rst_idx", {30'd0, beat_idx}, 32'd0);
    chk("rst_last", {31'd0, beat_last}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    reset_n = 1'b1;

    set_wbuf(32'hA0);
    request(1'b1, 32'h40, a);
    drain();
    request(1'b0, 32'h40, a);
    drain();

    // Second request held valid across the first burst.
    request(1'b0, 32'h40, a1);
    set_wbuf(32'hC0);
    request(1'b1, 32'h80, a2);
    chk("hold_accept_cycle", 32'(a2), 32'(a1 + LAT + BL + 1));
    drain();
    request(1'b0, 32'h80, a);
    drain();

    request(1'b0, 32'h48, a);
    drain();
    request(1'b0, 32'h0004_0040, a);
    drain();

    // Reset during the third write beat.
    set_wbuf(32'hB0);
    request(1'b1, 32'h40, a);
    for (int k = 0; k < 20 && cyc != a + LAT + 2; k++) begin
      @(negedge clk); #1;
    end
    chk("reach_beat3", 32'(cyc), 32'(a + LAT + 2));
    reset_n = 1'b0;
    q.delete();
    busy_to = -2;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_valid", {31'd0, beat_valid}, 32'd0);
    chk("abort_idx", {30'd0, beat_idx}, 32'd0);
    chk("abort_last", {31'd0, beat_last}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    reset_n = 1'b1;
    request(1'b0, 32'h40, a);
    drain();

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
